// File: rtl/al422_pkg.sv
// Shared AL422 definitions: row-header layout, writer states and header byte packing.
// The packing function is common to the frame writer and the al422_bam_bs reader.
package al422_pkg;

  localparam int AL422_HDR_LEN = 5;

  typedef enum logic [2:0] {
    HDR_CFG      = 3'd0,
    HDR_ACT_LO   = 3'd1,
    HDR_ACT_HI   = 3'd2,
    HDR_INACT_LO = 3'd3,
    HDR_INACT_HI = 3'd4
  } hdr_idx_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WRST = 2'd1,
    ST_HDR  = 2'd2,
    ST_PIX  = 2'd3
  } wr_state_e;

  function automatic logic [7:0] al422_cfg_byte(input logic oe_inv, input logic [4:0] row);
    return {2'b00, oe_inv, row};
  endfunction

  function automatic logic [7:0] al422_hdr_byte(
    input hdr_idx_e    idx,
    input logic        oe_inv,
    input logic [4:0]  row,
    input logic [15:0] active,
    input logic [15:0] inactive
  );
    logic [7:0] v;
    case (idx)
      HDR_CFG:      v = al422_cfg_byte(oe_inv, row);
      HDR_ACT_LO:   v = active[7:0];
      HDR_ACT_HI:   v = active[15:8];
      HDR_INACT_LO: v = inactive[7:0];
      HDR_INACT_HI: v = inactive[15:8];
      default:      v = 8'h00;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/al422_wr_phy.sv
// AL422 write-port driver: in_clk/2 WCK generator and slot registers for DI, /WE, /WRST.
// Slot values are captured only on ph==0 edges (WCK falling), so they are stable at WCK rise.
module al422_wr_phy (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_we_n,
  input  logic       i_wrst_n,
  input  logic [7:0] i_data,
  output logic       o_ph,
  output logic       o_wck,
  output logic       o_we_n,
  output logic       o_wrst_n,
  output logic [7:0] o_data
);

  logic       r_ph;
  logic       r_wck;
  logic       r_we_n;
  logic       r_wrst_n;
  logic [7:0] r_data;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ph     <= 1'b0;
      r_wck    <= 1'b0;
      r_we_n   <= 1'b1;
      r_wrst_n <= 1'b1;
      r_data   <= 8'h00;
    end else begin
      r_ph  <= ~r_ph;
      r_wck <= r_ph;
      if (!r_ph) begin
        r_we_n   <= i_we_n;
        r_wrst_n <= i_wrst_n;
        r_data   <= i_data;
      end
    end
  end

  assign o_ph     = r_ph;
  assign o_wck    = r_wck;
  assign o_we_n   = r_we_n;
  assign o_wrst_n = r_wrst_n;
  assign o_data   = r_data;

endmodule

// File: rtl/al422_frame_writer.sv
// Frame writer feeding the AL422 FIFO: pointer reset per frame, 5-byte header per row,
// rows written top-down, first pixel held in a one-byte skid register.
module al422_frame_writer #(
  parameter int ROWS      = 16,
  parameter int PIX_BYTES = 64,
  parameter int WRST_CYC  = 4
) (
  input  logic        in_clk,
  input  logic        in_rst,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  input  logic        s_sof,
  output logic        s_ready,
  input  logic        cfg_oe_inv,
  input  logic [15:0] cfg_active,
  input  logic [15:0] cfg_inactive,
  output logic        al422_wck_out,
  output logic        al422_we_out,
  output logic        al422_wrst_out,
  output logic [7:0]  al422_data_out,
  output logic        busy,
  output logic        frame_done,
  output logic        sync_err
);
  import al422_pkg::*;

  localparam logic [11:0] PIX_LAST  = 12'(PIX_BYTES - 1);
  localparam logic [4:0]  ROW_TOP   = 5'(ROWS - 1);
  localparam logic [15:0] WRST_LAST = 16'(WRST_CYC / 2 - 1);
  localparam logic [2:0]  HDR_LAST  = 3'(AL422_HDR_LEN - 1);

  wr_state_e   r_state;
  logic [7:0]  r_skid;
  logic        r_skid_full;
  logic        r_oe_inv;
  logic [15:0] r_active;
  logic [15:0] r_inactive;
  logic [4:0]  r_row;
  logic [11:0] r_pix_cnt;
  logic [2:0]  r_hdr_idx;
  logic [15:0] r_wrst_cnt;
  logic        r_fin;
  logic        r_s_ready;
  logic        r_busy;
  logic        r_frame_done;
  logic        r_sync_err;

  logic        w_ph;
  logic        w_accept;
  logic        w_slot_we_n;
  logic        w_slot_wrst_n;
  logic [7:0]  w_slot_data;

  assign w_accept = s_valid & r_s_ready;

  // Slot content presented to the PHY; it is only captured on ph==0 edges
  always_comb begin
    w_slot_we_n   = 1'b1;
    w_slot_wrst_n = 1'b1;
    w_slot_data   = 8'h00;
    case (r_state)
      ST_IDLE: begin
        w_slot_we_n = 1'b1;
      end
      ST_WRST: begin
        w_slot_wrst_n = 1'b0;
      end
      ST_HDR: begin
        w_slot_we_n = 1'b0;
        w_slot_data = al422_hdr_byte(hdr_idx_e'(r_hdr_idx), r_oe_inv, r_row, r_active, r_inactive);
      end
      ST_PIX: begin
        if (r_fin) begin
          w_slot_we_n = 1'b1;
        end else if (r_skid_full) begin
          w_slot_we_n = 1'b0;
          w_slot_data = r_skid;
        end else if (w_accept && !s_sof) begin
          w_slot_we_n = 1'b0;
          w_slot_data = s_data;
        end else begin
          w_slot_we_n = 1'b1;
        end
      end
      default: begin
        w_slot_we_n = 1'b1;
      end
    endcase
  end

  // Frame sequencing; r_fin keeps PIX alive one extra slot so /WE is high when frame_done fires
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      r_state      <= ST_IDLE;
      r_skid       <= 8'h00;
      r_skid_full  <= 1'b0;
      r_oe_inv     <= 1'b0;
      r_active     <= 16'h0000;
      r_inactive   <= 16'h0000;
      r_row        <= 5'd0;
      r_pix_cnt    <= 12'd0;
      r_hdr_idx    <= 3'd0;
      r_wrst_cnt   <= 16'd0;
      r_fin        <= 1'b0;
      r_s_ready    <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_sync_err   <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      r_sync_err   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_s_ready <= 1'b1;
          r_busy    <= 1'b0;
          if (w_accept && s_sof) begin
            r_skid      <= s_data;
            r_skid_full <= 1'b1;
            r_oe_inv    <= cfg_oe_inv;
            r_active    <= cfg_active;
            r_inactive  <= cfg_inactive;
            r_wrst_cnt  <= 16'd0;
            r_s_ready   <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= ST_WRST;
          end else if (w_accept) begin
            r_sync_err <= 1'b1;
          end
        end
        ST_WRST: begin
          r_s_ready <= 1'b0;
          if (!w_ph) begin
            if (r_wrst_cnt == WRST_LAST) begin
              r_row     <= ROW_TOP;
              r_hdr_idx <= 3'd0;
              r_state   <= ST_HDR;
            end else begin
              r_wrst_cnt <= r_wrst_cnt + 16'd1;
            end
          end
        end
        ST_HDR: begin
          r_s_ready <= 1'b0;
          if (!w_ph) begin
            if (r_hdr_idx == HDR_LAST) begin
              r_pix_cnt <= 12'd0;
              r_state   <= ST_PIX;
            end else begin
              r_hdr_idx <= r_hdr_idx + 3'd1;
            end
          end
        end
        ST_PIX: begin
          if (w_ph) begin
            r_s_ready <= ~r_fin & ~r_skid_full;
          end else begin
            r_s_ready <= 1'b0;
            if (r_fin) begin
              r_fin        <= 1'b0;
              r_frame_done <= 1'b1;
              r_busy       <= 1'b0;
              r_s_ready    <= 1'b1;
              r_state      <= ST_IDLE;
            end else if (w_accept && s_sof) begin
              r_sync_err  <= 1'b1;
              r_skid      <= s_data;
              r_skid_full <= 1'b1;
              r_oe_inv    <= cfg_oe_inv;
              r_active    <= cfg_active;
              r_inactive  <= cfg_inactive;
              r_wrst_cnt  <= 16'd0;
              r_state     <= ST_WRST;
            end else if (r_skid_full || w_accept) begin
              r_skid_full <= 1'b0;
              if (r_pix_cnt != PIX_LAST) begin
                r_pix_cnt <= r_pix_cnt + 12'd1;
              end else if (r_row == 5'd0) begin
                r_fin <= 1'b1;
              end else begin
                r_row     <= r_row - 5'd1;
                r_hdr_idx <= 3'd0;
                r_state   <= ST_HDR;
              end
            end
          end
        end
        default: begin
          r_s_ready <= 1'b0;
          r_busy    <= 1'b0;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

  al422_wr_phy u_phy (
    .i_clk    (in_clk),
    .i_rst    (in_rst),
    .i_we_n   (w_slot_we_n),
    .i_wrst_n (w_slot_wrst_n),
    .i_data   (w_slot_data),
    .o_ph     (w_ph),
    .o_wck    (al422_wck_out),
    .o_we_n   (al422_we_out),
    .o_wrst_n (al422_wrst_out),
    .o_data   (al422_data_out)
  );

  assign s_ready    = r_s_ready;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;
  assign sync_err   = r_sync_err;

endmodule
